rom_port_arbiter: RTL and testbench

- Shares one single-port synchronous program-ROM RAM between three requesters:
  - the download writer (ioctl stream),
  - the main CPU opcode/data fetch,
  - the sound CPU fetch.
- Replaces the dual-port ROM arrangement, so both CPUs can live in one RAM block.
- Sits between hps_io/download logic, the game core's ROM address/data buses, and the RAM macro.
- Uses a 4-phase-free req/ack handshake, with fixed write priority and round-robin read arbitration.

---
 rtl/rom_port_arbiter.sv | 258 +++++++++++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one single-port synchronous ROM RAM between the
// download writer and the main/sound CPU fetch ports. Writes have fixed
// priority through a one-entry buffer; reads are arbitrated round-robin.
// Optional feature macro: ROM_ARB_HOLD_EN (per-port last-address hit path).
module rom_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_data,
  output logic              dl_pending,
  output logic              dl_ovf,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_data,
  input  logic              snd_req,
  input  logic [ADDR_W-1:0] snd_addr,
  output logic              snd_ack,
  output logic [DATA_W-1:0] snd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  // RD lasts RAM_LAT+1 cycles: address cycle plus the RAM's own latency.
  localparam logic [1:0] LAST_RD_CNT = 2'(RAM_LAT);

  state_t            state_q, state_d;
  logic              buf_vld_q, buf_vld_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              ovf_q, ovf_d;
  logic              rr_snd_q, rr_snd_d;     // 1: sound port was granted last
  logic              gnt_snd_q, gnt_snd_d;   // port owning the current read
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_d_q, ram_d_d;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
  logic [DATA_W-1:0] snd_data_q, snd_data_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              snd_ack_q, snd_ack_d;

  logic              pick_snd_s;
  logic [ADDR_W-1:0] pick_addr_s;
  logic              hit_s;
  logic              drain_s;
  logic              rd_done_s;

  assign rd_done_s = (state_q == ST_RD) && (cnt_q == LAST_RD_CNT);

`ifdef ROM_ARB_HOLD_EN
  logic              cpu_hv_q, cpu_hv_d;
  logic [ADDR_W-1:0] cpu_ha_q, cpu_ha_d;
  logic              snd_hv_q, snd_hv_d;
  logic [ADDR_W-1:0] snd_ha_q, snd_ha_d;
`endif

  // Read-port selection: single requester wins, ties go to the port not granted last.
  always_comb begin
    pick_snd_s  = snd_req & (~cpu_req | ~rr_snd_q);
    pick_addr_s = pick_snd_s ? snd_addr : cpu_addr;
`ifdef ROM_ARB_HOLD_EN
    if (pick_snd_s) begin
      hit_s = snd_hv_q && (snd_ha_q == pick_addr_s);
    end else begin
      hit_s = cpu_hv_q && (cpu_ha_q == pick_addr_s);
    end
`else
    hit_s = 1'b0;
`endif
  end

  // Arbiter FSM next state and registered RAM/ack/data outputs.
  always_comb begin
    state_d    = state_q;
    rr_snd_d   = rr_snd_q;
    gnt_snd_d  = gnt_snd_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    ram_we_d   = 1'b0;
    ram_d_d    = ram_d_q;
    cpu_data_d = cpu_data_q;
    snd_data_d = snd_data_q;
    cpu_ack_d  = 1'b0;
    snd_ack_d  = 1'b0;
    drain_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (buf_vld_q) begin
          state_d    = ST_WR;
          ram_addr_d = buf_addr_q;
          ram_d_d    = buf_data_q;
          ram_we_d   = 1'b1;
          drain_s    = 1'b1;
        end else if (cpu_req || snd_req) begin
          rr_snd_d  = pick_snd_s;
          gnt_snd_d = pick_snd_s;
          if (hit_s) begin
            state_d   = ST_ACK;
            cpu_ack_d = ~pick_snd_s;
            snd_ack_d = pick_snd_s;
          end else begin
            state_d    = ST_RD;
            ram_addr_d = pick_addr_s;
            cnt_d      = 2'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
      end
      ST_RD: begin
        if (rd_done_s) begin
          state_d = ST_ACK;
          if (gnt_snd_q) begin
            snd_data_d = ram_q;
            snd_ack_d  = 1'b1;
          end else begin
            cpu_data_d = ram_q;
            cpu_ack_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Single-entry download buffer; a write arriving while it is full and not draining is lost.
  always_comb begin
    buf_vld_d  = buf_vld_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    ovf_d      = ovf_q;
    if (dl_wr) begin
      if (!buf_vld_q || drain_s) begin
        buf_vld_d  = 1'b1;
        buf_addr_d = dl_addr;
        buf_data_d = dl_data;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (drain_s) begin
      buf_vld_d = 1'b0;
    end else begin
      buf_vld_d = buf_vld_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      buf_vld_q  <= 1'b0;
      buf_addr_q <= {ADDR_W{1'b0}};
      buf_data_q <= {DATA_W{1'b0}};
      ovf_q      <= 1'b0;
      rr_snd_q   <= 1'b1;
      gnt_snd_q  <= 1'b0;
      cnt_q      <= 2'd0;
      ram_addr_q <= {ADDR_W{1'b0}};
      ram_we_q   <= 1'b0;
      ram_d_q    <= {DATA_W{1'b0}};
      cpu_data_q <= {DATA_W{1'b0}};
      snd_data_q <= {DATA_W{1'b0}};
      cpu_ack_q  <= 1'b0;
      snd_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_vld_q  <= buf_vld_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      ovf_q      <= ovf_d;
      rr_snd_q   <= rr_snd_d;
      gnt_snd_q  <= gnt_snd_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_d_q    <= ram_d_d;
      cpu_data_q <= cpu_data_d;
      snd_data_q <= snd_data_d;
      cpu_ack_q  <= cpu_ack_d;
      snd_ack_q  <= snd_ack_d;
    end
  end

`ifdef ROM_ARB_HOLD_EN
  // Last-address tags: set when a RAM read completes, wiped by any RAM write.
  always_comb begin
    cpu_hv_d = cpu_hv_q;
    cpu_ha_d = cpu_ha_q;
    snd_hv_d = snd_hv_q;
    snd_ha_d = snd_ha_q;
    if (state_q == ST_WR) begin
      cpu_hv_d = 1'b0;
      snd_hv_d = 1'b0;
    end else if (rd_done_s) begin
      if (gnt_snd_q) begin
        snd_hv_d = 1'b1;
        snd_ha_d = ram_addr_q;
      end else begin
        cpu_hv_d = 1'b1;
        cpu_ha_d = ram_addr_q;
      end
    end else begin
      cpu_hv_d = cpu_hv_q;
    end
  end

  // Last-address tag registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_hv_q <= 1'b0;
      cpu_ha_q <= {ADDR_W{1'b0}};
      snd_hv_q <= 1'b0;
      snd_ha_q <= {ADDR_W{1'b0}};
    end else begin
      cpu_hv_q <= cpu_hv_d;
      cpu_ha_q <= cpu_ha_d;
      snd_hv_q <= snd_hv_d;
      snd_ha_q <= snd_ha_d;
    end
  end
`endif

  assign dl_pending = buf_vld_q;
  assign dl_ovf     = ovf_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_data   = cpu_data_q;
  assign snd_ack    = snd_ack_q;
  assign snd_data   = snd_data_q;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_d      = ram_d_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Testbench for rom_port_arbiter: directed scenarios plus a randomized phase
// checked against a memory-content model and fairness/latency rules.
module tb_rom_port_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        dl_wr   = 1'b0;
  logic [15:0] dl_addr = 16'h0000;
  logic [7:0]  dl_data = 8'h00;
  logic        dl_pending, dl_ovf;
  logic        cpu_req = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_ack;
  logic [7:0]  cpu_data;
  logic        snd_req = 1'b0;
  logic [15:0] snd_addr = 16'h0000;
  logic        snd_ack;
  logic [7:0]  snd_data;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_d;
  logic [7:0]  ram_q = 8'h00;

  int vectors = 0;
  int miscompares = 0;

  rom_port_arbiter #(.ADDR_W(16), .DATA_W(8), .RAM_LAT(1)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_pending(dl_pending), .dl_ovf(dl_ovf),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
    .snd_req(snd_req), .snd_addr(snd_addr), .snd_ack(snd_ack), .snd_data(snd_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q)
  );

  always #5 clk_sys = ~clk_sys;

  // Power-up ROM image: a fixed function of the address (0x0123 holds 0xA5).
  function automatic logic [7:0] ram_init(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h87;
  endfunction

  // Synchronous single-port RAM, one cycle read latency.
  logic [7:0] ram_mem [0:65535];
  bit         ram_wv  [0:65535];
  always @(posedge clk_sys) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_d;
      ram_wv[ram_addr]  <= 1'b1;
    end
    ram_q <= ram_wv[ram_addr] ? ram_mem[ram_addr] : ram_init(ram_addr);
  end

  // Reference contents: writes the bench issued that must have landed.
  logic [7:0] ref_wr [int];
  function automatic logic [7:0] exp_data(input logic [15:0] a);
    if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
    return ram_init(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Issue one read on a port from IDLE and check data, latency and ack width.
  task automatic do_read(input string tag, input bit is_snd, input logic [15:0] a, input int exp_lat);
    int lat = -1;
    if (is_snd) begin snd_req = 1'b1; snd_addr = a; end
    else begin cpu_req = 1'b1; cpu_addr = a; end
    for (int i = 1; i <= 30; i++) begin
      tick();
      if ((is_snd ? snd_ack : cpu_ack) && lat < 0) begin
        lat = i;
        check({tag, "_data"}, is_snd ? snd_data : cpu_data, exp_data(a));
        check({tag, "_other_ack"}, is_snd ? cpu_ack : snd_ack, 1'b0);
        cpu_req = 1'b0;
        snd_req = 1'b0;
        break;
      end
    end
    check({tag, "_acked"}, (lat > 0), 1'b1);
    if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
    tick();
    check({tag, "_ack_1cyc"}, is_snd ? snd_ack : cpu_ack, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int ack_t, we_t, we_n, n_acks, seen;
    int ack_port [$];
    int ack_time [$];
    logic [15:0] raddr [2];
    bit          rwait [2];
    int          rlat  [2];
    int          ropp  [2];
    int          wr_gap;
    bit          ackp;

    // Reset state
    do_reset();
    check("rst_outputs", {dl_pending, dl_ovf, cpu_ack, snd_ack, ram_we}, 5'b0);
    check("rst_ram_addr", ram_addr, 16'h0000);
    check("rst_data", {cpu_data, snd_data, ram_d}, 24'h0);

    // Single cpu read of 0x0123 (0xA5), ack three cycles after grant
    check("t1_init", ram_init(16'h0123), 8'hA5);
    do_read("t1", 1'b0, 16'h0123, 3);

    // Both ports requesting continuously: cpu first, then alternate
    do_reset();
    cpu_addr = 16'h0010; snd_addr = 16'h8010;
    cpu_req = 1'b1; snd_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cpu_ack && snd_ack) check("t2_dual_ack", 1'b1, 1'b0);
      if (cpu_ack) begin
        ack_port.push_back(0); ack_time.push_back(i);
        check("t2_cpu_data", cpu_data, exp_data(16'h0010));
      end
      if (snd_ack) begin
        ack_port.push_back(1); ack_time.push_back(i);
        check("t2_snd_data", snd_data, exp_data(16'h8010));
      end
    end
    cpu_req = 1'b0; snd_req = 1'b0;
    check("t2_n_acks_ge4", (ack_port.size() >= 4), 1'b1);
    if (ack_port.size() > 0) begin
      check("t2_first_cpu", ack_port[0], 0);
`ifndef ROM_ARB_HOLD_EN
      check("t2_first_time", ack_time[0], 3);
`endif
    end
    for (int k = 1; k < ack_port.size(); k++) begin
      check("t2_alternate", ack_port[k], 1 - ack_port[k-1]);
`ifndef ROM_ARB_HOLD_EN
      check("t2_period", ack_time[k] - ack_time[k-1], 4);
`endif
    end
    repeat (6) tick();

    // Download write during a cpu read waits until the read completes
    cpu_addr = 16'h0300; cpu_req = 1'b1;
    tick();
    dl_wr = 1'b1; dl_addr = 16'h0200; dl_data = 8'h3C;
    tick();
    dl_wr = 1'b0;
    ref_wr[int'(16'h0200)] = 8'h3C;
    check("t4_pending", dl_pending, 1'b1);
    ack_t = -1; we_t = -1; we_n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (cpu_ack && ack_t < 0) begin
        ack_t = i;
        check("t4_rd_data", cpu_data, exp_data(16'h0300));
        cpu_req = 1'b0;
      end
      if (ram_we) begin
        we_n++;
        if (we_t < 0) begin
          we_t = i;
          check("t4_wr_addr", ram_addr, 16'h0200);
          check("t4_wr_data", ram_d, 8'h3C);
        end
      end
    end
    check("t4_order", (ack_t > 0 && we_t > ack_t), 1'b1);
    check("t4_we_cycles", we_n, 1);
    check("t4_drained", dl_pending, 1'b0);
    do_read("t4_rb", 1'b0, 16'h0200, 3);

    // Two writes back to back during a read: the second is lost
    cpu_addr = 16'h0301; cpu_req = 1'b1;
    tick();
    dl_wr = 1'b1; dl_addr = 16'h0210; dl_data = 8'h11;
    tick();
    dl_addr = 16'h0211; dl_data = 8'h22;
    tick();
    dl_wr = 1'b0;
    ref_wr[int'(16'h0210)] = 8'h11;
    check("t5_ovf_set", dl_ovf, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (cpu_ack) cpu_req = 1'b0;
    end
    check("t5_ovf_sticky", dl_ovf, 1'b1);
    do_read("t5_first", 1'b0, 16'h0210, 3);
    do_read("t5_dropped", 1'b0, 16'h0211, 3);
    check("t5_ovf_still", dl_ovf, 1'b1);

    // Reset in the middle of a read aborts it without an ack
    cpu_addr = 16'h0123; cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    reset = 1'b1;
    tick();
    check("t6_outputs", {dl_pending, dl_ovf, cpu_ack, snd_ack, ram_we}, 5'b0);
    check("t6_ram_addr", ram_addr, 16'h0000);
    check("t6_data", {cpu_data, snd_data}, 16'h0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ack || snd_ack) seen++;
    end
    check("t6_no_ack", seen, 0);
    do_read("t6_after", 1'b0, 16'h0123, 3);

    // Repeat read of one address; a download write forces a RAM access again
    do_read("t7_a", 1'b0, 16'h0040, 3);
`ifdef ROM_ARB_HOLD_EN
    do_read("t7_hit", 1'b0, 16'h0040, 1);
`else
    do_read("t7_b", 1'b0, 16'h0040, 3);
`endif
    dl_wr = 1'b1; dl_addr = 16'h5000; dl_data = 8'h77;
    tick();
    dl_wr = 1'b0;
    ref_wr[int'(16'h5000)] = 8'h77;
    repeat (4) tick();
    do_read("t7_after_wr", 1'b0, 16'h0040, 3);

    // Randomized traffic on both ports with sparse download writes
    for (int p = 0; p < 2; p++) begin rwait[p] = 1'b0; rlat[p] = 0; ropp[p] = 0; raddr[p] = 16'h1000; end
    wr_gap = 0;
    n_acks = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cpu_ack && snd_ack) check("rnd_dual_ack", 1'b1, 1'b0);
      for (int p = 0; p < 2; p++) begin
        ackp = (p == 1) ? snd_ack : cpu_ack;
        if (ackp) begin
          n_acks++;
          check("rnd_spurious", rwait[p], 1'b1);
          check("rnd_data", (p == 1) ? snd_data : cpu_data, exp_data(raddr[p]));
          check("rnd_latency", (rlat[p] <= 16), 1'b1);
          check("rnd_fair", (ropp[p] <= 1), 1'b1);
          rwait[p] = 1'b0;
          if (rwait[1-p]) ropp[1-p]++;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!rwait[p] && ($urandom % 2 == 0)) begin
          rwait[p] = 1'b1;
          raddr[p] = 16'h1000 + 16'($urandom % 16);
          rlat[p]  = 0;
          ropp[p]  = 0;
        end
      end
      cpu_req = rwait[0]; cpu_addr = raddr[0];
      snd_req = rwait[1]; snd_addr = raddr[1];
      dl_wr = 1'b0;
      if (wr_gap > 0) begin
        wr_gap--;
      end else if ($urandom % 8 == 0) begin
        dl_wr   = 1'b1;
        dl_addr = 16'h4000 + 16'($urandom % 64);
        dl_data = 8'($urandom);
        ref_wr[int'(dl_addr)] = dl_data;
        wr_gap  = 10;
      end
      tick();
      for (int p = 0; p < 2; p++) if (rwait[p]) rlat[p]++;
    end
    cpu_req = 1'b0; snd_req = 1'b0; dl_wr = 1'b0;
    repeat (20) tick();
    check("rnd_some_acks", (n_acks > 100), 1'b1);
    check("rnd_no_ovf", dl_ovf, 1'b0);
    check("rnd_idle_pending", dl_pending, 1'b0);
    seen = 0;
    foreach (ref_wr[k]) begin
      if (k >= 32'h4000 && k < 32'h4040 && seen < 6) begin
        do_read("rnd_wr_rb", seen[0], 16'(k), -1);
        seen++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
